tb_status_responder: RTL and testbench
======================================

Name: tb_status_responder

Overview:
- Memory-mapped responder on the core data bus. It is the device side of the test-status/stdout interface that the testbench top monitors.
- It accepts OBI-style load/store requests from the CV32E40P data port and buffers stdout characters in a FIFO drained over a valid/ready handshake.
- It produces the tests_passed/tests_failed/exit_valid/exit_value indications that end simulation.
- It sits inside the tb wrapper, beside the dual-port RAM, selected by address decode.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte base of the 16-byte register window; must be 16-byte aligned.
- FIFO_DEPTH, 8, stdout FIFO entries; power of two, 2..64.

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  request valid; address already decoded to this window by the wrapper
- data_gnt_o  out  1  request accepted this cycle
- data_addr_i  in  32  byte address
- data_we_i  in  1  1 = store, 0 = load
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  store data
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  32  load data; 0 when data_rvalid_o = 0
- data_err_o  out  1  error response; see Optional Feature
- char_valid_o  out  1  FIFO head valid
- char_data_o  out  8  FIFO head byte
- char_ready_i  in  1  consumer takes head when char_valid_o && char_ready_i
- tests_passed_o  out  1  sticky pass flag
- tests_failed_o  out  1  sticky fail flag
- exit_valid_o  out  1  sticky exit flag
- exit_value_o  out  32  exit code

Behaviour:
- Reset (async assert, sync release): every output is 0, the FIFO is empty, the cycle counter is 0, and any pending rvalid is dropped.
- Register map, offset = data_addr_i[3:2]:
  - 0x0 STDOUT. W: if be[0], push wdata[7:0]. R: {24'b0, count[7:0]}, where count is the FIFO occupancy.
  - 0x4 EXIT. W (any be non-zero): exit_value_o <= wdata and exit_valid_o <= 1. The first write wins; later writes are ignored.
  - 0x8 STATUS. W: wdata == 1 sets tests_passed_o; any other value sets tests_failed_o. Once either flag is set, both flags are frozen. R: {29'b0, exit_valid, failed, passed}.
  - 0xC CYCLE. R: 32-bit free-running counter, +1 every cycle after reset, wraps 0xFFFF_FFFF -> 0. W: ignored.
  - Address bits [31:4] != BASE_ADDR[31:4]: unmapped. Reads return 0; writes have no effect.
- Grant:
  - data_gnt_o = data_req_i && !(STDOUT store && fifo_full).
  - fifo_full is the registered state. A pop in the same cycle does not un-stall the push; the grant follows the next cycle.
- Response:
  - Exactly one data_rvalid_o pulse, registered, in the cycle after each grant.
  - Back-to-back grants yield back-to-back rvalid. No outstanding limit beyond 1 in flight per cycle.
  - rdata is captured at grant time. A CYCLE read returns the count value sampled in the grant cycle.
  - Stores return rvalid with rdata = 0.
- Side effects (register writes, FIFO push) occur on the grant edge.
- FIFO:
  - char_valid_o = !empty; char_data_o = head entry.
  - A pop and a push in the same cycle when non-empty and not full: count is unchanged and both operations complete.
  - A push into an empty FIFO is visible on char_valid_o the next cycle.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Status flags and exit are sticky until reset; they do not depend on FIFO drain.

Optional Feature:
- Macro: TB_STATUS_RESP_ERR_EN.
- Defined:
  - An unmapped access, a CYCLE write, or an EXIT/STATUS write with be == 0 returns rvalid with data_err_o = 1 in the same cycle. data_err_o = 0 on every other rvalid.
  - data_err_o is 0 whenever rvalid is 0.
- Undefined: data_err_o is tied to 0; all such accesses complete silently as above.

Test Plan:
- Reset, then store 0x41, 0x42 to STDOUT with char_ready_i = 0 -> gnt each request; rvalid one cycle later; STDOUT read returns 0x2; char_data_o = 0x41. Raise ready -> 0x41 then 0x42 popped, char_valid_o drops.
- Fill FIFO with 8 stores, ready = 0; attempt a 9th -> gnt held 0. Pulse ready one cycle -> gnt asserts the following cycle, count returns to 8, order preserved.
- Store 1 to STATUS -> tests_passed_o = 1 next cycle. Then store 0 -> tests_failed_o stays 0. STATUS read returns 0x1.
- Store 0x5 to EXIT, then 0x7 -> exit_valid_o = 1, exit_value_o = 0x5. Assert rst_ni low mid-response -> all outputs 0 immediately, no rvalid.
- Two CYCLE reads granted 10 cycles apart -> rdata difference = 10. Read of BASE_ADDR + 0x10 -> rdata 0; data_err_o = 1 only with TB_STATUS_RESP_ERR_EN.
- Push and pop in the same cycle with count = 3 -> count stays 3 and correct bytes emitted; the same with count = 0 -> no pop, count 1.

Source files
------------

// File: rtl/tb_status_responder.sv
// Test-status / stdout responder on the core data bus: stdout FIFO, exit code, pass/fail flags, cycle counter.
// Optional error responses are enabled with `define TB_STATUS_RESP_ERR_EN.
module tb_status_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [1:0] OFF_STDOUT = 2'd0;
    localparam logic [1:0] OFF_EXIT   = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CYCLE  = 2'd3;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             passed_q, failed_q, exit_valid_q;
    logic [31:0]      exit_value_q, cycle_q;
    logic             rvalid_q;
    logic [31:0]      rdata_q;

    logic        mapped_c, fifo_full_c, stdout_st_c, gnt_c, push_c, pop_c;
    logic        wr_exit_c, wr_status_c;
    logic [1:0]  off_c;
    logic [31:0] rd_data_c;
    logic        unused_addr_c;

    assign unused_addr_c = ^data_addr_i[1:0];
    assign mapped_c      = (data_addr_i[31:4] == BASE_ADDR[31:4]);
    assign off_c         = data_addr_i[3:2];
    assign fifo_full_c   = (count_q == CNT_W'(FIFO_DEPTH));
    assign stdout_st_c   = mapped_c && (off_c == OFF_STDOUT) && data_we_i;
    assign gnt_c         = data_req_i && !(stdout_st_c && fifo_full_c);
    assign push_c        = gnt_c && stdout_st_c && data_be_i[0];
    assign pop_c         = (count_q != '0) && char_ready_i;
    assign wr_exit_c     = gnt_c && mapped_c && data_we_i && (off_c == OFF_EXIT) && (data_be_i != 4'b0);
    assign wr_status_c   = gnt_c && mapped_c && data_we_i && (off_c == OFF_STATUS) && (data_be_i != 4'b0);

    // Load data as seen in the grant cycle; unmapped reads return 0.
    always_comb begin
        rd_data_c = 32'b0;
        if (mapped_c) begin
            case (off_c)
                OFF_STDOUT: rd_data_c = 32'(count_q);
                OFF_STATUS: rd_data_c = {29'b0, exit_valid_q, failed_q, passed_q};
                OFF_CYCLE:  rd_data_c = cycle_q;
                default:    rd_data_c = 32'b0;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wptr_q] <= data_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_value_q <= 32'b0;
            cycle_q      <= 32'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'b0;
        end else begin
            cycle_q  <= cycle_q + 32'd1;
            rvalid_q <= gnt_c;
            rdata_q  <= (gnt_c && !data_we_i) ? rd_data_c : 32'b0;
            count_q  <= count_d;
            if (push_c) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (wr_exit_c && !exit_valid_q) begin
                exit_valid_q <= 1'b1;
                exit_value_q <= data_wdata_i;
            end
            // First status write decides the verdict; both flags freeze afterwards.
            if (wr_status_c && !passed_q && !failed_q) begin
                if (data_wdata_i == 32'd1) begin
                    passed_q <= 1'b1;
                end else begin
                    failed_q <= 1'b1;
                end
            end
        end
    end

`ifdef TB_STATUS_RESP_ERR_EN
    logic err_q;
    logic err_cond_c;

    assign err_cond_c = !mapped_c
                     || (data_we_i && (off_c == OFF_CYCLE))
                     || (data_we_i && ((off_c == OFF_EXIT) || (off_c == OFF_STATUS)) && (data_be_i == 4'b0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= gnt_c && err_cond_c;
        end
    end

    assign data_err_o = err_q;
`else
    assign data_err_o = 1'b0;
`endif

    assign data_gnt_o     = gnt_c;
    assign data_rvalid_o  = rvalid_q;
    assign data_rdata_o   = rdata_q;
    assign char_valid_o   = (count_q != '0);
    assign char_data_o    = mem_q[rptr_q];
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_tb_status_responder.sv
// Self-checking bench for tb_status_responder: directed steps plus random traffic against a queue-based model.
module tb_tb_status_responder;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;
`ifdef TB_STATUS_RESP_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic [31:0] data_addr_i = 32'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'b0;
    logic [31:0] data_wdata_i = 32'b0;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        char_valid_o;
    logic [7:0]  char_data_o;
    logic        char_ready_i = 1'b0;
    logic        tests_passed_o, tests_failed_o, exit_valid_o;
    logic [31:0] exit_value_o;

    int n_checks = 0;
    int n_err = 0;

    tb_status_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .char_valid_o(char_valid_o), .char_data_o(char_data_o), .char_ready_i(char_ready_i),
        .tests_passed_o(tests_passed_o), .tests_failed_o(tests_failed_o),
        .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [7:0]  m_q[$];
    bit          m_pass, m_fail, m_exv;
    logic [31:0] m_exval, m_cycle;
    bit          e_rvalid, e_err;
    logic [31:0] e_rdata;

    function automatic bit is_mapped(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic bit m_gnt();
        return data_req_i && !(is_mapped(data_addr_i) && data_addr_i[3:2] == 2'd0
                               && data_we_i && m_q.size() == DEPTH);
    endfunction

    function automatic logic [31:0] m_read();
        if (!is_mapped(data_addr_i)) return 32'b0;
        case (data_addr_i[3:2])
            2'd0:    return 32'(m_q.size());
            2'd2:    return {29'b0, m_exv, m_fail, m_pass};
            2'd3:    return m_cycle;
            default: return 32'b0;
        endcase
    endfunction

    function automatic bit m_errc();
        logic [1:0] off = data_addr_i[3:2];
        return !is_mapped(data_addr_i) || (data_we_i && off == 2'd3)
            || (data_we_i && (off == 2'd1 || off == 2'd2) && data_be_i == 4'b0);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pass = 0; m_fail = 0; m_exv = 0; m_exval = 0; m_cycle = 0;
        e_rvalid = 0; e_err = 0; e_rdata = 0;
    endtask

    task automatic model_tick();
        bit g, pop, push, mp;
        logic [1:0] off;
        g    = m_gnt();
        mp   = is_mapped(data_addr_i);
        off  = data_addr_i[3:2];
        pop  = char_ready_i && m_q.size() > 0;
        push = g && mp && off == 2'd0 && data_we_i && data_be_i[0];
        e_rvalid = g;
        e_rdata  = (g && !data_we_i) ? m_read() : 32'b0;
        e_err    = ERR && g && m_errc();
        if (g && mp && data_we_i && data_be_i != 4'b0) begin
            if (off == 2'd1 && !m_exv) begin
                m_exv = 1; m_exval = data_wdata_i;
            end
            if (off == 2'd2 && !m_pass && !m_fail) begin
                if (data_wdata_i == 32'd1) m_pass = 1; else m_fail = 1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(data_wdata_i[7:0]);
        m_cycle = m_cycle + 32'd1;
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) model_reset();
        else model_tick();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(data_gnt_o), 32'(m_gnt()));
        chk("rvalid", 32'(data_rvalid_o), 32'(e_rvalid));
        chk("rdata", data_rdata_o, e_rdata);
        chk("err", 32'(data_err_o), 32'(e_err));
        chk("char_valid", 32'(char_valid_o), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("char_data", 32'(char_data_o), 32'(m_q[0]));
        chk("passed", 32'(tests_passed_o), 32'(m_pass));
        chk("failed", 32'(tests_failed_o), 32'(m_fail));
        chk("exit_valid", 32'(exit_valid_o), 32'(m_exv));
        chk("exit_value", exit_value_o, m_exval);
    endtask

    task automatic step();
        @(negedge clk_i);
        check_all();
        @(posedge clk_i);
        #1;
    endtask

    task automatic access(input logic [31:0] addr, input bit we, input logic [3:0] be,
                          input logic [31:0] wdata, input bit rnd_ready);
        bit done = 0;
        data_req_i = 1; data_addr_i = addr; data_we_i = we; data_be_i = be; data_wdata_i = wdata;
        for (int i = 0; i < 60 && !done; i++) begin
            if (rnd_ready) char_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            check_all();
            done = m_gnt();
            @(posedge clk_i);
            #1;
        end
        data_req_i = 0; data_we_i = 0; data_be_i = 0;
        if (!done) begin
            n_checks++; n_err++;
            $error("FAIL gnt_timeout: observed=no grant expected=grant addr=0x%08h", addr);
        end
    endtask

    task automatic read_expect(input logic [31:0] addr, input logic [31:0] expv, input string tag);
        access(addr, 0, 4'hF, 32'b0, 0);
        @(negedge clk_i);
        chk(tag, data_rdata_o, expv);
        check_all();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        data_req_i = 0; char_ready_i = 0;
        rst_ni = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] c1, c2, a;
        logic [1:0]  off;

        // Reset values
        do_reset();
        @(negedge clk_i);
        chk("rst_rvalid", 32'(data_rvalid_o), 0);
        chk("rst_char_valid", 32'(char_valid_o), 0);
        chk("rst_exit_value", exit_value_o, 0);
        check_all();
        @(posedge clk_i); #1;

        // Two stdout characters with consumer stalled, then drain
        access(BASE, 1, 4'h1, 32'h41, 0);
        access(BASE, 1, 4'h1, 32'h42, 0);
        read_expect(BASE, 32'd2, "stdout_count2");
        @(negedge clk_i);
        chk("head_41", 32'(char_data_o), 32'h41);
        @(posedge clk_i); #1;
        char_ready_i = 1;
        repeat (3) step();
        char_ready_i = 0;
        chk("drained", 32'(char_valid_o), 0);

        // Fill the FIFO, stall the ninth push, release with a one-cycle pop
        for (int i = 0; i < DEPTH; i++) access(BASE, 1, 4'h1, 32'h50 + 32'(i), 0);
        data_req_i = 1; data_addr_i = BASE; data_we_i = 1; data_be_i = 4'h1; data_wdata_i = 32'h58;
        repeat (3) begin
            @(negedge clk_i);
            chk("full_stall", 32'(data_gnt_o), 0);
            check_all();
            @(posedge clk_i); #1;
        end
        char_ready_i = 1;
        @(negedge clk_i);
        chk("pop_no_unstall", 32'(data_gnt_o), 0);
        check_all();
        @(posedge clk_i); #1;
        char_ready_i = 0;
        @(negedge clk_i);
        chk("gnt_after_pop", 32'(data_gnt_o), 1);
        check_all();
        @(posedge clk_i); #1;
        data_req_i = 0; data_we_i = 0;
        read_expect(BASE, 32'd8, "stdout_count8");
        char_ready_i = 1;
        repeat (10) step();
        char_ready_i = 0;

        // Status flags: first write decides, later ones frozen
        access(BASE + 32'h8, 1, 4'hF, 32'd1, 0);
        @(negedge clk_i);
        chk("passed_set", 32'(tests_passed_o), 1);
        @(posedge clk_i); #1;
        access(BASE + 32'h8, 1, 4'hF, 32'd0, 0);
        @(negedge clk_i);
        chk("failed_frozen", 32'(tests_failed_o), 0);
        @(posedge clk_i); #1;
        read_expect(BASE + 32'h8, 32'h1, "status_read");

        // Exit: first write wins
        access(BASE + 32'h4, 1, 4'hF, 32'h5, 0);
        access(BASE + 32'h4, 1, 4'hF, 32'h7, 0);
        @(negedge clk_i);
        chk("exit_valid_set", 32'(exit_valid_o), 1);
        chk("exit_value_first", exit_value_o, 32'h5);
        check_all();
        @(posedge clk_i); #1;

        // Reset asserted while a response is in flight
        access(BASE + 32'hC, 0, 4'hF, 32'b0, 0);
        rst_ni = 0;
        #1;
        chk("midrst_rvalid", 32'(data_rvalid_o), 0);
        chk("midrst_rdata", data_rdata_o, 0);
        chk("midrst_passed", 32'(tests_passed_o), 0);
        chk("midrst_exit_valid", 32'(exit_valid_o), 0);
        chk("midrst_exit_value", exit_value_o, 0);
        do_reset();

        // Two cycle-counter reads granted ten cycles apart
        data_req_i = 1; data_addr_i = BASE + 32'hC; data_we_i = 0; data_be_i = 4'hF;
        @(negedge clk_i); check_all();
        @(posedge clk_i); #1;
        data_req_i = 0;
        @(negedge clk_i); check_all();
        c1 = data_rdata_o;
        repeat (9) @(posedge clk_i);
        #1;
        data_req_i = 1;
        @(negedge clk_i); check_all();
        @(posedge clk_i); #1;
        data_req_i = 0;
        @(negedge clk_i); check_all();
        c2 = data_rdata_o;
        chk("cycle_diff", c2 - c1, 32'd10);
        @(posedge clk_i); #1;

        // Unmapped read
        access(BASE + 32'h10, 0, 4'hF, 32'b0, 0);
        @(negedge clk_i);
        chk("unmapped_rdata", data_rdata_o, 0);
        chk("unmapped_err", 32'(data_err_o), 32'(ERR));
        check_all();
        @(posedge clk_i); #1;

        // Simultaneous push and pop at count 3, then at count 0
        for (int i = 0; i < 3; i++) access(BASE, 1, 4'h1, 32'h61 + 32'(i), 0);
        data_req_i = 1; data_addr_i = BASE; data_we_i = 1; data_be_i = 4'h1; data_wdata_i = 32'h64;
        char_ready_i = 1;
        step();
        data_req_i = 0; data_we_i = 0; char_ready_i = 0;
        read_expect(BASE, 32'd3, "pushpop_count3");
        char_ready_i = 1;
        repeat (4) step();
        data_req_i = 1; data_addr_i = BASE; data_we_i = 1; data_be_i = 4'h1; data_wdata_i = 32'h70;
        step();
        data_req_i = 0; data_we_i = 0; char_ready_i = 0;
        read_expect(BASE, 32'd1, "pushpop_count1");

        // Random traffic
        do_reset();
        for (int n = 0; n < 250; n++) begin
            off = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? (BASE + 32'h10 * 32'($urandom_range(1, 15)))
                                            : (BASE + {28'b0, off, 2'b00});
            if (off == 2'd2)
                access(a, 1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 2)), 1);
            else
                access(a, ($urandom_range(0, 2) != 0), 4'($urandom), $urandom, 1);
            if ($urandom_range(0, 3) == 0) step();
        end
        char_ready_i = 1;
        repeat (12) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
